rom_fetch_sequencer: RTL

- Sequences the byte-wide, asynchronous 512x8 instruction ROM.
- Issues four consecutive byte addresses per instruction and assembles the bytes big-endian into a 32-bit SPARC instruction word.
- Presents the word to the decode stage with a valid/ready handshake.
- Owns the fetch PC: sequential +4 advance, plus redirect from branch/trap logic.

---
 rtl/rom_fetch_sequencer_if.sv | 26 ++
 rtl/rom_fetch_sequencer.sv | 105 ++++++++++
 2 files changed

// File: rtl/rom_fetch_sequencer_if.sv
// Fetch-sequencer bus: ROM address/data, decode valid/ready handshake, redirect and error flag.
interface rom_fetch_sequencer_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
);
  logic              fetch_en;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              fetch_err;

  modport master (
    input  fetch_en, redirect, redirect_pc, rom_data, instr_ready,
    output rom_addr, instr, instr_pc, instr_valid, fetch_err
  );

  modport slave (
    output fetch_en, redirect, redirect_pc, rom_data, instr_ready,
    input  rom_addr, instr, instr_pc, instr_valid, fetch_err
  );
endinterface

// File: rtl/rom_fetch_sequencer.sv
// Byte-serial ROM fetch into 32-bit big-endian words with valid/ready output and PC redirect.
// Optional misaligned-redirect trap state compiled in with FETCH_ALIGN_CHECK_EN.
module rom_fetch_sequencer #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  rom_fetch_sequencer_if.master bus
);

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {FETCH, HOLD, ERR} state_t;
`else
  typedef enum logic [1:0] {FETCH, HOLD} state_t;
`endif

  state_t            state;
  logic [1:0]        cnt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] instr_pc;
  logic [31:0]       instr;
  logic              instr_valid;
  logic [DATA_W-1:0] byte_in;
  logic [ADDR_W-1:0] target;

  assign byte_in = bus.rom_data;
  assign target  = bus.redirect_pc & ~ADDR_W'(3);

  // pc is always word-aligned, so pc + cnt stays inside the current word
  always_comb begin
    bus.rom_addr = pc;
    if (state == FETCH) bus.rom_addr = pc + ADDR_W'(cnt);
  end

  assign bus.instr       = instr;
  assign bus.instr_pc    = instr_pc;
  assign bus.instr_valid = instr_valid;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fetch_err;
  assign bus.fetch_err = fetch_err;
`else
  assign bus.fetch_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      cnt         <= '0;
      pc          <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_err   <= 1'b0;
`endif
    end else if (bus.redirect) begin
      // a coincident HOLD transfer is already complete; only the next pc changes
      pc          <= target;
      cnt         <= '0;
      instr_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      if (bus.redirect_pc[1:0] != 2'b00) begin
        state     <= ERR;
        fetch_err <= 1'b1;
      end else begin
        state     <= FETCH;
        fetch_err <= 1'b0;
      end
`else
      state       <= FETCH;
`endif
    end else begin
      case (state)
        FETCH: begin
          if (bus.fetch_en) begin
            case (cnt)
              2'd0:    instr[31:24] <= byte_in;
              2'd1:    instr[23:16] <= byte_in;
              2'd2:    instr[15:8]  <= byte_in;
              default: instr[7:0]   <= byte_in;
            endcase
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              state       <= HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.instr_ready) begin
            instr_valid <= 1'b0;
            pc          <= pc + ADDR_W'(4);
            cnt         <= '0;
            state       <= FETCH;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
